// File: rtl/intpol_mc_pkg.sv
// Shared types and helpers for the multi-channel interpolator core.
package intpol_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_EMIT,
        ST_FINISH
    } state_t;

    localparam logic [1:0] MODE_LINEAR = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_BYPASS = 2'd2;

    // Upsample exponents above the supported maximum saturate to it.
    function automatic int unsigned clamp_log2_l(input int unsigned val, input int unsigned lmax);
        return (val > lmax) ? lmax : val;
    endfunction

    // Mode 3 is an alias of bypass, so only the upper mode bit matters.
    function automatic logic is_bypass(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/intpol_mc_lerp.sv
// Per-channel combinational datapath: linear interpolation step or hold/bypass pass-through.
module intpol_mc_lerp
    import intpol_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_LMAX  = 4,
    parameter int LW         = 3
) (
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] x1,
    input  logic [LOG2_LMAX-1:0]  k,
    input  logic [LW-1:0]         log2_l,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] y
);

    // Wide enough for (x1-x0)*k without overflow.
    localparam int PW = DATA_WIDTH + 1 + LOG2_LMAX;

    logic signed [DATA_WIDTH:0] diff;
    logic signed [PW-1:0]       diff_ext;
    logic signed [PW-1:0]       k_ext;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       scaled;
    logic signed [PW-1:0]       sum;
    logic                       unused_sum_hi;

    // Arithmetic shift floors toward -inf; result stays between x0 and x1, so the low bits are exact.
    always_comb begin
        diff     = {x1[DATA_WIDTH-1], x1} - {x0[DATA_WIDTH-1], x0};
        diff_ext = {{LOG2_LMAX{diff[DATA_WIDTH]}}, diff};
        k_ext    = {{(PW-LOG2_LMAX){1'b0}}, k};
        prod     = diff_ext * k_ext;
        scaled   = prod >>> log2_l;
        sum      = scaled + {{(PW-DATA_WIDTH){x0[DATA_WIDTH-1]}}, x0};
        if (mode == MODE_LINEAR) begin
            y = sum[DATA_WIDTH-1:0];
        end else begin
            y = x1;
        end
    end

    assign unused_sum_hi = ^sum[PW-1:DATA_WIDTH];

endmodule

// File: rtl/intpol_mc_core.sv
// Multi-channel interpolator: lockstep FIFO fetch, L outputs per input step, stall and done status.
module intpol_mc_core
    import intpol_mc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_LMAX  = 4,
    parameter int LEN_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_a,
    input  logic                         start,
    input  logic [$clog2(LOG2_LMAX+1)-1:0] cfg_log2_l,
    input  logic [1:0]                   cfg_mode,
    input  logic [LEN_W-1:0]             cfg_len,
    input  logic                         empty_i,
    input  logic                         afull_i,
    output logic                         rd_en_o,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    output logic                         wr_en_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout,
    output logic                         busy_o,
    output logic                         stop_empty_o,
    output logic                         stop_afull_o,
    output logic                         done_o
);

    localparam int LW = $clog2(LOG2_LMAX+1);
    localparam int KW = LOG2_LMAX;
    localparam int BW = NUM_CH*DATA_WIDTH;

    state_t               state_reg, state_next;
    logic [LW-1:0]        log2_l_reg;
    logic [1:0]           mode_reg;
    logic [LEN_W-1:0]     len_reg;
    logic [LEN_W-1:0]     n_reg;
    logic [KW-1:0]        k_reg;
    logic [BW-1:0]        x0_reg;
    logic [BW-1:0]        x1_reg;
    logic [BW-1:0]        f_val;
    logic [KW:0]          lact_m1;
    logic                 accept;
    logic                 issue;
    logic                 k_last;
    logic                 n_last;

    // A start coinciding with the done pulse is dropped so one run can't chain into the next by accident.
    assign accept = start && (state_reg == ST_IDLE) && !done_o;
    assign issue  = (state_reg == ST_EMIT) && !afull_i;
    assign k_last = ({1'b0, k_reg} == lact_m1);
    assign n_last = (({1'b0, n_reg} + (LEN_W+1)'(1)) == {1'b0, len_reg});

    // Last output index within one input step: L-1, or 0 in bypass.
    always_comb begin
        lact_m1 = '0;
        if (!is_bypass(mode_reg)) begin
            lact_m1 = ((KW+1)'(1) << log2_l_reg) - (KW+1)'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            intpol_mc_lerp #(
                .DATA_WIDTH (DATA_WIDTH),
                .LOG2_LMAX  (LOG2_LMAX),
                .LW         (LW)
            ) u_lerp (
                .x0     (x0_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
                .x1     (x1_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
                .k      (k_reg),
                .log2_l (log2_l_reg),
                .mode   (mode_reg),
                .y      (f_val[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (cfg_len == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!empty_i) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_next = ST_EMIT;
            ST_EMIT: begin
                if (issue && k_last) begin
                    state_next = n_last ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Combinational strobes and status derived from the current state.
    always_comb begin
        busy_o       = (state_reg != ST_IDLE);
        rd_en_o      = (state_reg == ST_FETCH) && !empty_i;
        stop_empty_o = (state_reg == ST_FETCH) && empty_i;
        stop_afull_o = (state_reg == ST_EMIT) && afull_i;
    end

    // Registered output word, its valid strobe and the end-of-run pulse.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wr_en_o <= 1'b0;
            dout    <= '0;
            done_o  <= 1'b0;
        end else begin
            wr_en_o <= issue;
            done_o  <= (state_reg == ST_FINISH);
            if (issue) begin
                dout <= f_val;
            end
        end
    end

    // Config latch, sample pair and step/sample counters.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            log2_l_reg <= '0;
            mode_reg   <= MODE_LINEAR;
            len_reg    <= '0;
            n_reg      <= '0;
            k_reg      <= '0;
            x0_reg     <= '0;
            x1_reg     <= '0;
        end else begin
            if (accept) begin
                log2_l_reg <= LW'(clamp_log2_l(int'(cfg_log2_l), int'(LOG2_LMAX)));
                mode_reg   <= cfg_mode;
                len_reg    <= cfg_len;
                n_reg      <= '0;
                k_reg      <= '0;
                x0_reg     <= '0;
            end
            if (state_reg == ST_CAPTURE) begin
                x1_reg <= din;
                k_reg  <= '0;
            end
            if (issue) begin
                if (k_last) begin
                    x0_reg <= x1_reg;
                    n_reg  <= n_reg + LEN_W'(1);
                    k_reg  <= '0;
                end else begin
                    k_reg <= k_reg + KW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_intpol_mc_core.sv
// Directed bench for intpol_mc_core with a registered-output FIFO model and an output monitor.
module tb_intpol_mc_core;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_a = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    cfg_log2_l = '0;
    logic [1:0]    cfg_mode = '0;
    logic [15:0]   cfg_len = '0;
    logic          empty_i;
    logic          afull_i = 1'b0;
    logic          rd_en_o;
    logic [31:0]   din = '0;
    logic          wr_en_o;
    logic [31:0]   dout;
    logic          busy_o, stop_empty_o, stop_afull_o, done_o;

    intpol_mc_core #(.NUM_CH(2), .DATA_WIDTH(DW), .LOG2_LMAX(4), .LEN_W(16)) dut (
        .clk(clk), .rst_a(rst_a), .start(start), .cfg_log2_l(cfg_log2_l),
        .cfg_mode(cfg_mode), .cfg_len(cfg_len), .empty_i(empty_i), .afull_i(afull_i),
        .rd_en_o(rd_en_o), .din(din), .wr_en_o(wr_en_o), .dout(dout), .busy_o(busy_o),
        .stop_empty_o(stop_empty_o), .stop_afull_o(stop_afull_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // FIFO model: registered output, data appears the cycle after rd_en_o.
    logic [31:0] fifo_mem [0:15];
    int fifo_base = 0;
    int fifo_cnt  = 0;
    int rd_ptr    = 0;
    int cyc       = 0;
    logic force_empty = 1'b0;
    assign empty_i = force_empty || (rd_ptr >= fifo_base + fifo_cnt);

    always @(posedge clk) begin
        cyc++;
        if (rd_en_o && (rd_ptr - fifo_base) < fifo_cnt) begin
            din <= fifo_mem[rd_ptr - fifo_base];
            rd_ptr++;
        end
    end

    // Monitor sampled on the falling edge.
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, stop_e_cnt = 0, stop_a_cnt = 0, afull_viol = 0;
    int wr_before_done = 0, done_cyc = 0;
    logic afull_last = 1'b0;
    logic signed [DW-1:0] out0 [$];
    logic signed [DW-1:0] out1 [$];

    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            wr_before_done = wr_cnt;
            done_cyc = cyc;
        end
        if (wr_en_o) begin
            wr_cnt++;
            out0.push_back(dout[15:0]);
            out1.push_back(dout[31:16]);
        end
        if (wr_en_o && afull_last) afull_viol++;
        afull_last = afull_i;
        if (rd_en_o) rd_cnt++;
        if (stop_empty_o) stop_e_cnt++;
        if (stop_afull_o) stop_a_cnt++;
    end

    task automatic load_fifo(input int c0a, input int c1a, input int c0b, input int c1b, input int n);
        fifo_mem[0] = {16'(c1a), 16'(c0a)};
        fifo_mem[1] = {16'(c1b), 16'(c0b)};
        fifo_base   = rd_ptr;
        fifo_cnt    = n;
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [2:0] l2, input int len, output int s_cyc);
        @(posedge clk);
        #1;
        cfg_mode   = mode;
        cfg_log2_l = l2;
        cfg_len    = 16'(len);
        start      = 1'b1;
        s_cyc      = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_o) begin
                timed_out = 1'b0;
                break;
            end
        end
        #1;
    endtask

    task automatic wait_wr(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wr_en_o) begin
                timed_out = 1'b0;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({wr_en_o, rd_en_o, done_o, busy_o, stop_empty_o, stop_afull_o} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000",
                     {wr_en_o, rd_en_o, done_o, busy_o, stop_empty_o, stop_afull_o});
        else n_pass++;
        n_checks++;
        if (dout !== 32'h0) $display("FAIL reset_dout: got %h expected 0", dout);
        else n_pass++;
    endtask

    task automatic test_linear();
        int e0 [8] = '{0, 25, 50, 75, 100, 125, 150, 175};
        int e1 [8] = '{0, -2, -4, -6, -8, -4, 0, 4};
        int b = out0.size();
        int wb = wr_cnt, db = done_cnt, rb = rd_cnt, s;
        bit to;
        logic signed [DW-1:0] got, exp;
        load_fifo(100, -8, 200, 8, 2);
        start_run(2'd0, 3'd2, 2, s);
        wait_done(to);
        n_checks++;
        if (to) $display("FAIL linear_done_timeout: got timeout expected done_o");
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            got = (b + i < out0.size()) ? out0[b+i] : 'x;
            exp = 16'(e0[i]);
            n_checks++;
            if (got !== exp) $display("FAIL linear_ch0[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
            got = (b + i < out1.size()) ? out1[b+i] : 'x;
            exp = 16'(e1[i]);
            n_checks++;
            if (got !== exp) $display("FAIL linear_ch1[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (wr_cnt - wb !== 8) $display("FAIL linear_wr_count: got %0d expected 8", wr_cnt - wb);
        else n_pass++;
        n_checks++;
        if (done_cnt - db !== 1) $display("FAIL linear_done_count: got %0d expected 1", done_cnt - db);
        else n_pass++;
        n_checks++;
        if (wr_before_done - wb !== 8)
            $display("FAIL linear_done_after_last_wr: got %0d writes before done expected 8", wr_before_done - wb);
        else n_pass++;
        n_checks++;
        if (done_cyc - s !== 14) $display("FAIL linear_latency: got %0d cycles expected 14", done_cyc - s);
        else n_pass++;
        n_checks++;
        if (rd_cnt - rb !== 2) $display("FAIL linear_rd_count: got %0d expected 2", rd_cnt - rb);
        else n_pass++;
    endtask

    task automatic test_rounding();
        int e0 [4] = '{0, 0, 1, 2};
        int e1 [4] = '{0, -1, -2, -3};
        int b = out0.size(), s;
        bit to;
        logic signed [DW-1:0] got, exp;
        load_fifo(3, -3, 0, 0, 1);
        start_run(2'd0, 3'd2, 1, s);
        wait_done(to);
        n_checks++;
        if (to) $display("FAIL rounding_done_timeout: got timeout expected done_o");
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (b + i < out0.size()) ? out0[b+i] : 'x;
            exp = 16'(e0[i]);
            n_checks++;
            if (got !== exp) $display("FAIL rounding_pos[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
            got = (b + i < out1.size()) ? out1[b+i] : 'x;
            exp = 16'(e1[i]);
            n_checks++;
            if (got !== exp) $display("FAIL rounding_neg[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        int e0 [4] = '{5, 5, 9, 9};
        int b = out0.size(), wb = wr_cnt, s;
        bit to;
        logic signed [DW-1:0] got, exp;
        load_fifo(5, -5, 9, -9, 2);
        start_run(2'd1, 3'd1, 2, s);
        wait_done(to);
        n_checks++;
        if (wr_cnt - wb !== 4 || to) $display("FAIL hold_wr_count: got %0d expected 4", wr_cnt - wb);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (b + i < out0.size()) ? out0[b+i] : 'x;
            exp = 16'(e0[i]);
            n_checks++;
            if (got !== exp) $display("FAIL hold_ch0[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
            got = (b + i < out1.size()) ? out1[b+i] : 'x;
            exp = 16'(-e0[i]);
            n_checks++;
            if (got !== exp) $display("FAIL hold_ch1[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        int e0 [2] = '{5, 9};
        for (int m = 2; m < 4; m++) begin
            int b = out0.size(), wb = wr_cnt, s;
            bit to;
            logic signed [DW-1:0] got, exp;
            load_fifo(5, 1, 9, 2, 2);
            start_run(2'(m), 3'd3, 2, s);
            wait_done(to);
            n_checks++;
            if (wr_cnt - wb !== 2 || to)
                $display("FAIL bypass_m%0d_wr_count: got %0d expected 2", m, wr_cnt - wb);
            else n_pass++;
            for (int i = 0; i < 2; i++) begin
                got = (b + i < out0.size()) ? out0[b+i] : 'x;
                exp = 16'(e0[i]);
                n_checks++;
                if (got !== exp) $display("FAIL bypass_m%0d[%0d]: got %0d expected %0d", m, i, got, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall_empty();
        int b, rb, eb, s;
        bit to;
        logic signed [DW-1:0] got;
        load_fifo(7, 3, 0, 0, 1);
        force_empty = 1'b1;
        start_run(2'd1, 3'd1, 1, s);
        rb = rd_cnt;
        eb = stop_e_cnt;
        b  = out0.size();
        repeat (10) @(posedge clk);
        #1 force_empty = 1'b0;
        n_checks++;
        if (stop_e_cnt - eb !== 10) $display("FAIL empty_stop_cycles: got %0d expected 10", stop_e_cnt - eb);
        else n_pass++;
        n_checks++;
        if (rd_cnt - rb !== 0) $display("FAIL empty_no_read: got %0d reads expected 0", rd_cnt - rb);
        else n_pass++;
        wait_done(to);
        for (int i = 0; i < 2; i++) begin
            got = (b + i < out0.size()) ? out0[b+i] : 'x;
            n_checks++;
            if (got !== 16'sd7 || to) $display("FAIL empty_resume[%0d]: got %0d expected 7", i, got);
            else n_pass++;
        end
    endtask

    task automatic test_stall_afull();
        int e0 [8] = '{0, 25, 50, 75, 100, 125, 150, 175};
        int b = out0.size(), wb = wr_cnt, ab = stop_a_cnt, vb = afull_viol, s;
        bit to;
        logic signed [DW-1:0] got, exp;
        load_fifo(100, -8, 200, 8, 2);
        start_run(2'd0, 3'd2, 2, s);
        wait_wr(to);
        n_checks++;
        if (to) $display("FAIL afull_first_wr_timeout: got timeout expected wr_en_o");
        else n_pass++;
        @(posedge clk);
        #1 afull_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 afull_i = 1'b0;
        wait_done(to);
        n_checks++;
        if (stop_a_cnt - ab !== 3) $display("FAIL afull_stop_cycles: got %0d expected 3", stop_a_cnt - ab);
        else n_pass++;
        n_checks++;
        if (afull_viol - vb !== 0) $display("FAIL afull_wr_during_stall: got %0d expected 0", afull_viol - vb);
        else n_pass++;
        n_checks++;
        if (wr_cnt - wb !== 8 || to) $display("FAIL afull_wr_count: got %0d expected 8", wr_cnt - wb);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            got = (b + i < out0.size()) ? out0[b+i] : 'x;
            exp = 16'(e0[i]);
            n_checks++;
            if (got !== exp) $display("FAIL afull_seq[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_len_zero();
        int wb = wr_cnt, rb = rd_cnt, db = done_cnt, s;
        bit to;
        load_fifo(1, 1, 2, 2, 2);
        start_run(2'd0, 3'd2, 0, s);
        wait_done(to);
        n_checks++;
        if (done_cyc - s !== 2 || to) $display("FAIL len0_done_latency: got %0d expected 2", done_cyc - s);
        else n_pass++;
        n_checks++;
        if ((rd_cnt - rb) + (wr_cnt - wb) !== 0)
            $display("FAIL len0_no_traffic: got %0d rd %0d wr expected 0 0", rd_cnt - rb, wr_cnt - wb);
        else n_pass++;
        n_checks++;
        if (done_cnt - db !== 1) $display("FAIL len0_done_count: got %0d expected 1", done_cnt - db);
        else n_pass++;
        fifo_cnt = 0;
        fifo_base = rd_ptr;
    endtask

    task automatic test_clamp();
        int b = out0.size(), wb = wr_cnt, s;
        bit to;
        logic signed [DW-1:0] got, exp;
        load_fifo(16, -16, 0, 0, 1);
        start_run(2'd0, 3'd7, 1, s);
        wait_done(to);
        n_checks++;
        if (wr_cnt - wb !== 16 || to) $display("FAIL clamp_wr_count: got %0d expected 16", wr_cnt - wb);
        else n_pass++;
        for (int i = 0; i < 16; i += 5) begin
            got = (b + i < out0.size()) ? out0[b+i] : 'x;
            exp = 16'(i);
            n_checks++;
            if (got !== exp) $display("FAIL clamp_ch0[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
            got = (b + i < out1.size()) ? out1[b+i] : 'x;
            exp = 16'(-i);
            n_checks++;
            if (got !== exp) $display("FAIL clamp_ch1[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_start_busy();
        int e0 [4] = '{5, 5, 9, 9};
        int b = out0.size(), db = done_cnt, rb, s;
        bit to;
        logic signed [DW-1:0] got, exp;
        load_fifo(5, 5, 9, 9, 2);
        start_run(2'd1, 3'd1, 2, s);
        repeat (3) @(posedge clk);
        #1;
        cfg_mode = 2'd2; cfg_len = 16'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(to);
        n_checks++;
        if (done_cnt - db !== 1 || to) $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt - db);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (b + i < out0.size()) ? out0[b+i] : 'x;
            exp = 16'(e0[i]);
            n_checks++;
            if (got !== exp) $display("FAIL busy_start_seq[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
        end
        // start raised while done_o is high must be dropped
        load_fifo(4, 4, 0, 0, 1);
        rb = rd_cnt;
        cfg_mode = 2'd0; cfg_log2_l = 3'd1; cfg_len = 16'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL start_on_done_busy: got %b expected 0", busy_o);
        else n_pass++;
        n_checks++;
        if (rd_cnt - rb !== 0) $display("FAIL start_on_done_reads: got %0d expected 0", rd_cnt - rb);
        else n_pass++;
        fifo_cnt = 0;
        fifo_base = rd_ptr;
    endtask

    task automatic test_reset_midrun();
        int e0 [4] = '{0, 25, 50, 75};
        int e1 [4] = '{0, -2, -4, -6};
        int b, db = done_cnt, s;
        bit to;
        logic signed [DW-1:0] got, exp;
        load_fifo(100, -8, 200, 8, 2);
        start_run(2'd0, 3'd2, 2, s);
        wait_wr(to);
        @(posedge clk);
        #1 rst_a = 1'b0;
        #1;
        n_checks++;
        if ({wr_en_o, rd_en_o, done_o, busy_o, stop_empty_o, stop_afull_o} !== 6'b0 || to)
            $display("FAIL midrun_reset_flags: got %b expected 000000",
                     {wr_en_o, rd_en_o, done_o, busy_o, stop_empty_o, stop_afull_o});
        else n_pass++;
        n_checks++;
        if (dout !== 32'h0) $display("FAIL midrun_reset_dout: got %h expected 0", dout);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b1;
        n_checks++;
        if (done_cnt - db !== 0) $display("FAIL midrun_no_done: got %0d expected 0", done_cnt - db);
        else n_pass++;
        b = out0.size();
        load_fifo(100, -8, 0, 0, 1);
        start_run(2'd0, 3'd2, 1, s);
        wait_done(to);
        for (int i = 0; i < 4; i++) begin
            got = (b + i < out0.size()) ? out0[b+i] : 'x;
            exp = 16'(e0[i]);
            n_checks++;
            if (got !== exp || to) $display("FAIL after_reset_ch0[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
            got = (b + i < out1.size()) ? out1[b+i] : 'x;
            exp = 16'(e1[i]);
            n_checks++;
            if (got !== exp) $display("FAIL after_reset_ch1[%0d]: got %0d expected %0d", i, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_rounding();
        test_hold();
        test_bypass();
        test_stall_empty();
        test_stall_afull();
        test_len_zero();
        test_clamp();
        test_start_busy();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
